wb_reg_file: RTL and testbench

Write-back stage and architectural register file for the 5-stage MIPS pipeline. Consumes the MEM→WB pipeline register outputs, selects the write-back value (load data or ALU result), and commits it to a 32-entry register file. Provides two read ports to the ID stage with same-cycle write-through bypass, so ID never needs a separate WB→ID forwarding path. Also exports the selected write-back value and destination for the EX-stage forwarding unit.

---
 rtl/wb_reg_file_if.sv | 30 +++
 rtl/wb_reg_file.sv | 65 ++++++
 tb/tb_wb_reg_file.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/wb_reg_file_if.sv
// Bus between the MEM->WB pipeline register / ID stage and the write-back
// register file. The master drives the pipeline-register outputs and read
// indices; the slave (register file) returns read data and write-back info.
interface wb_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              WB_EN;
  logic              MEM_R_EN;
  logic [DATA_W-1:0] ALURes;
  logic [DATA_W-1:0] memReadVal;
  logic [ADDR_W-1:0] dest;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [DATA_W-1:0] wbValue;
  logic [ADDR_W-1:0] wbDest;
  logic              wbWrite;

  modport master (
    output WB_EN, MEM_R_EN, ALURes, memReadVal, dest, src1, src2,
    input  reg1, reg2, wbValue, wbDest, wbWrite
  );

  modport slave (
    input  WB_EN, MEM_R_EN, ALURes, memReadVal, dest, src1, src2,
    output reg1, reg2, wbValue, wbDest, wbWrite
  );
endinterface

// File: rtl/wb_reg_file.sv
// Write-back stage and architectural register file. Selects load data or
// ALU result, commits it to the register file, and serves two combinational
// read ports with optional same-cycle write-through so ID sees the value
// being written this cycle. Register 0 is hardwired to zero.
module wb_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input logic           clk,
  input logic           rst,
  wb_reg_file_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] wb_value;
  logic              wb_write;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Write-back value select and commit qualification; reset suppresses
  // any commit so a write pending when rst rises is dropped.
  always_comb begin
    wb_value = bus.MEM_R_EN ? bus.memReadVal : bus.ALURes;
    wb_write = bus.WB_EN & (bus.dest != '0) & ~rst;
  end

  // Register array: asynchronous clear, single write port on the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write) begin
      regs[bus.dest] <= wb_value;
    end
  end

  // Read ports: index 0 and reset force zero; the write-through path only
  // fires on a real commit, so it never leaks a value into register 0.
  always_comb begin
    rd1 = regs[bus.src1];
    rd2 = regs[bus.src2];
    if (BYPASS && wb_write && (bus.src1 == bus.dest)) begin
      rd1 = wb_value;
    end
    if (BYPASS && wb_write && (bus.src2 == bus.dest)) begin
      rd2 = wb_value;
    end
    if (rst || (bus.src1 == '0)) begin
      rd1 = '0;
    end
    if (rst || (bus.src2 == '0)) begin
      rd2 = '0;
    end
  end

  // Outputs toward ID and the EX-stage forwarding unit.
  assign bus.reg1    = rd1;
  assign bus.reg2    = rd2;
  assign bus.wbValue = wb_value;
  assign bus.wbWrite = wb_write;
  assign bus.wbDest  = wb_write ? bus.dest : '0;
endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file. Two instances share the same stimulus:
// one with write-through bypass enabled and one without, so both read-port
// behaviours are compared against hand-computed expectations every cycle.
module tb_wb_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    string       name;
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [31:0] exp_reg1_byp;
    logic [31:0] exp_reg2_byp;
    logic [31:0] exp_reg1_nb;
    logic [31:0] exp_reg2_nb;
    logic [31:0] exp_value;
    logic [4:0]  exp_dest;
    logic        exp_write;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  wb_reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) busB ();
  wb_reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) busN ();

  wb_reg_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  wb_reg_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dutN (
    .clk (clk),
    .rst (rst),
    .bus (busN.slave)
  );

  always #5 clk = ~clk;

  vec_t vecs [17];

  // Drive identical inputs into both instances.
  task automatic applyStimulus(input logic wb_en, input logic mem_r_en,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [4:0] dest, input logic [4:0] src1,
                               input logic [4:0] src2);
    busB.WB_EN = wb_en;  busB.MEM_R_EN = mem_r_en;
    busB.ALURes = alu;   busB.memReadVal = mem;
    busB.dest = dest;    busB.src1 = src1;  busB.src2 = src2;
    busN.WB_EN = wb_en;  busN.MEM_R_EN = mem_r_en;
    busN.ALURes = alu;   busN.memReadVal = mem;
    busN.dest = dest;    busN.src1 = src1;  busN.src2 = src2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic checkVec(input vec_t v);
    checkOutput({v.name, " reg1 byp"}, busB.reg1, v.exp_reg1_byp);
    checkOutput({v.name, " reg2 byp"}, busB.reg2, v.exp_reg2_byp);
    checkOutput({v.name, " reg1 nobyp"}, busN.reg1, v.exp_reg1_nb);
    checkOutput({v.name, " reg2 nobyp"}, busN.reg2, v.exp_reg2_nb);
    checkOutput({v.name, " wbValue"}, busB.wbValue, v.exp_value);
    checkOutput({v.name, " wbDest"}, {27'd0, busB.wbDest}, {27'd0, v.exp_dest});
    checkOutput({v.name, " wbWrite"}, {31'd0, busB.wbWrite}, {31'd0, v.exp_write});
    checkOutput({v.name, " wbWrite nobyp"}, {31'd0, busN.wbWrite}, {31'd0, v.exp_write});
  endtask

  initial begin
    //         name       en  ld  alu           mem           dst  s1  s2  r1byp         r2byp         r1nb          r2nb          value         wdst wr
    vecs[0]  = '{"aluwr",  1, 0, 32'h0000_1234, 32'h0,        5,   5,  0,  32'h0000_1234, 32'h0,        32'h0,        32'h0,        32'h0000_1234, 5,  1};
    vecs[1]  = '{"aluchk", 0, 0, 32'h0,        32'h0,        0,   5,  5,  32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'h0,        0,  0};
    vecs[2]  = '{"ldwr",   1, 1, 32'h1111_1111, 32'hDEAD_BEEF, 9,   9,  5,  32'hDEAD_BEEF, 32'h0000_1234, 32'h0,        32'h0000_1234, 32'hDEAD_BEEF, 9,  1};
    vecs[3]  = '{"ldchk",  0, 1, 32'h42,       32'hCAFE,     9,   9,  0,  32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'hCAFE,     0,  0};
    vecs[4]  = '{"wr7",    1, 0, 32'h10,       32'h0,        7,   0,  9,  32'h0,        32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 32'h10,       7,  1};
    vecs[5]  = '{"byp7",   1, 0, 32'h20,       32'h0,        7,   7,  7,  32'h20,       32'h20,       32'h10,       32'h10,       32'h20,       7,  1};
    vecs[6]  = '{"chk7",   0, 0, 32'h0,        32'h0,        0,   7,  7,  32'h20,       32'h20,       32'h20,       32'h20,       32'h0,        0,  0};
    vecs[7]  = '{"zerowr", 1, 0, 32'hFFFF_FFFF, 32'h0,        0,   0,  0,  32'h0,        32'h0,        32'h0,        32'h0,        32'hFFFF_FFFF, 0,  0};
    vecs[8]  = '{"zerochk",0, 0, 32'h0,        32'h0,        0,   0,  7,  32'h0,        32'h20,       32'h0,        32'h20,       32'h0,        0,  0};
    vecs[9]  = '{"wr3",    1, 0, 32'h77,       32'h0,        3,   3,  3,  32'h77,       32'h77,       32'h0,        32'h0,        32'h77,       3,  1};
    vecs[10] = '{"dis3a",  0, 0, 32'h55,       32'h0,        3,   3,  3,  32'h77,       32'h77,       32'h77,       32'h77,       32'h55,       0,  0};
    vecs[11] = '{"dis3b",  0, 0, 32'h55,       32'h0,        3,   3,  3,  32'h77,       32'h77,       32'h77,       32'h77,       32'h55,       0,  0};
    vecs[12] = '{"b2b_a",  1, 0, 32'hA,        32'h0,        12,  12, 0,  32'hA,        32'h0,        32'h0,        32'h0,        32'hA,        12, 1};
    vecs[13] = '{"b2b_b",  1, 0, 32'hB,        32'h0,        12,  12, 12, 32'hB,        32'hB,        32'hA,        32'hA,        32'hB,        12, 1};
    vecs[14] = '{"b2bchk", 0, 0, 32'h0,        32'h0,        0,   12, 12, 32'hB,        32'hB,        32'hB,        32'hB,        32'h0,        0,  0};
    vecs[15] = '{"wr31",   1, 0, 32'h3131_3131, 32'h0,        31,  31, 30, 32'h3131_3131, 32'h0,        32'h0,        32'h0,        32'h3131_3131, 31, 1};
    vecs[16] = '{"chk31",  0, 0, 32'h0,        32'h0,        0,   31, 31, 32'h3131_3131, 32'h3131_3131, 32'h3131_3131, 32'h3131_3131, 32'h0,        0,  0};

    // Reset state with a write attempt presented while rst is high.
    applyStimulus(1'b1, 1'b0, 32'h0000_0099, 32'h0, 5'd4, 5'd4, 5'd4);
    #1;
    checkOutput("por reg1", busB.reg1, 32'h0);
    checkOutput("por reg2", busB.reg2, 32'h0);
    checkOutput("por wbWrite", {31'd0, busB.wbWrite}, 32'h0);
    checkOutput("por wbDest", {27'd0, busB.wbDest}, 32'h0);
    checkOutput("por wbValue", busB.wbValue, 32'h99);
    @(posedge clk);
    #1;
    checkOutput("por edge reg1", busN.reg1, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table: drive after negedge, check, let the posedge commit.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].wb_en, vecs[i].mem_r_en, vecs[i].alu, vecs[i].mem,
                    vecs[i].dest, vecs[i].src1, vecs[i].src2);
      #1;
      checkVec(vecs[i]);
      @(negedge clk);
    end

    // Reset corner: fill regs 1..31, then assert rst between edges.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 32'hA5A5_0000 + i, 32'h0, i[4:0], 5'd0, 5'd0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd31);
    #1;
    checkOutput("fill reg1", busN.reg1, 32'hA5A5_0001);
    checkOutput("fill reg2", busN.reg2, 32'hA5A5_001F);
    applyStimulus(1'b1, 1'b0, 32'h0000_0099, 32'h0, 5'd4, 5'd4, 5'd31);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst async reg1", busB.reg1, 32'h0);
    checkOutput("rst async reg2", busB.reg2, 32'h0);
    checkOutput("rst wbWrite", {31'd0, busB.wbWrite}, 32'h0);
    checkOutput("rst wbDest", {27'd0, busB.wbDest}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd31);
    @(posedge clk);
    #1;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, i[4:0], i[4:0]);
      #1;
      checkOutput($sformatf("postrst r%0d byp", i), busB.reg1, 32'h0);
      checkOutput($sformatf("postrst r%0d nobyp", i), busN.reg2, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
